// File: rtl/bridge_sequencer_if.sv
// bridge_sequencer_if: requester/bridge signal bundle for bridge_sequencer.
// slave is the sequencer side, master the requester/bridge environment side.
interface bridge_sequencer_if #(parameter int W = 8);
    logic         ENA;
    logic         REQ0;
    logic         REQ1;
    logic [W-1:0] A0;
    logic [W-1:0] B0;
    logic [W-1:0] A1;
    logic [W-1:0] B1;
    logic [W-1:0] BRA;
    logic [W-1:0] BRB;
    logic [W-1:0] BRZ;
    logic [1:0]   GNT;
    logic [1:0]   ACK;
    logic [W-1:0] RES;
    logic         BUSY;
    modport slave (
        input  ENA, REQ0, REQ1, A0, B0, A1, B1, BRZ,
        output BRA, BRB, GNT, ACK, RES, BUSY
    );
    modport master (
        output ENA, REQ0, REQ1, A0, B0, A1, B1, BRZ,
        input  BRA, BRB, GNT, ACK, RES, BUSY
    );
endinterface

// File: rtl/bridge_sequencer.sv
// bridge_sequencer: two-port arbiter/sequencer for the combinational bridge datapath.
// Round-robin by default; define BRIDGE_SEQ_FIXPRIO_EN for fixed priority to requester 0.
module bridge_sequencer #(
    parameter int W   = 8,
    parameter int LAT = 1
) (
    input logic                CLK,
    input logic                RST,
    bridge_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);
    state_t       r_state;
    logic [3:0]   r_cnt;
    logic [W-1:0] r_bra;
    logic [W-1:0] r_brb;
    logic [W-1:0] r_res;
    logic [1:0]   r_gnt;
    logic [1:0]   r_ack;
    logic         r_busy;
    logic         w_any;
    logic         w_win;
    assign w_any = bus.REQ0 | bus.REQ1;
`ifdef BRIDGE_SEQ_FIXPRIO_EN
    assign w_win = ~bus.REQ0;
`else
    logic r_ptr;
    // under contention the requester not granted last wins
    assign w_win = (bus.REQ0 & bus.REQ1) ? ~r_ptr : bus.REQ1;
    always_ff @(posedge CLK or negedge RST)
        if (!RST)
            r_ptr <= 1'b1;
        else if (r_state == IDLE && bus.ENA && w_any)
            r_ptr <= w_win;
`endif
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bra   <= '0;
            r_brb   <= '0;
            r_res   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.ENA && w_any) begin
                    r_bra   <= w_win ? bus.A1 : bus.A0;
                    r_brb   <= w_win ? bus.B1 : bus.B0;
                    r_gnt   <= w_win ? 2'b10 : 2'b01;
                    r_cnt   <= CNT_INIT;
                    r_busy  <= 1'b1;
                    r_state <= WAIT;
                end
                WAIT: if (r_cnt != 4'd0)
                    r_cnt <= r_cnt - 4'd1;
                else begin
                    r_res   <= bus.BRZ;
                    r_ack   <= r_gnt;
                    r_state <= DONE;
                end
                DONE: begin
                    r_ack   <= '0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.BRA  = r_bra;
    assign bus.BRB  = r_brb;
    assign bus.RES  = r_res;
    assign bus.GNT  = r_gnt;
    assign bus.ACK  = r_ack;
    assign bus.BUSY = r_busy;
endmodule

// File: tb/tb_bridge_sequencer.sv
// tb_bridge_sequencer: random + directed bench for bridge_sequencer (LAT=1 and LAT=4 instances)
// against a transaction-timing model; honours BRIDGE_SEQ_FIXPRIO_EN.
module tb_bridge_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bridge_sequencer_if #(.W(8)) ifa ();
    bridge_sequencer_if #(.W(8)) ifb ();
    bridge_sequencer #(.W(8), .LAT(1)) u_lat1 (.CLK(clk), .RST(rst_n), .bus(ifa));
    bridge_sequencer #(.W(8), .LAT(4)) u_lat4 (.CLK(clk), .RST(rst_n), .bus(ifb));

    logic       d_ena [2];
    logic [1:0] d_req [2];
    logic [7:0] d_a0 [2], d_b0 [2], d_a1 [2], d_b1 [2];
    assign ifa.ENA = d_ena[0];
    assign ifa.REQ0 = d_req[0][0];
    assign ifa.REQ1 = d_req[0][1];
    assign ifa.A0 = d_a0[0];
    assign ifa.B0 = d_b0[0];
    assign ifa.A1 = d_a1[0];
    assign ifa.B1 = d_b1[0];
    assign ifb.ENA = d_ena[1];
    assign ifb.REQ0 = d_req[1][0];
    assign ifb.REQ1 = d_req[1][1];
    assign ifb.A0 = d_a0[1];
    assign ifb.B0 = d_b0[1];
    assign ifb.A1 = d_a1[1];
    assign ifb.B1 = d_b1[1];

    function automatic logic [7:0] f(input logic [7:0] a, input logic [7:0] b);
        return (a + {b[3:0], b[7:4]}) ^ 8'h3c;
    endfunction

    // the LAT=4 bridge reports garbage until its operands have been stable for 4 edges
    logic [7:0] pa1 = '0, pb1 = '0;
    int age1 = 0;
    always @(negedge clk)
        if (ifb.BRA !== pa1 || ifb.BRB !== pb1) begin
            pa1 <= ifb.BRA;
            pb1 <= ifb.BRB;
            age1 <= 0;
        end else if (age1 < 100)
            age1 <= age1 + 1;
    assign ifa.BRZ = f(ifa.BRA, ifa.BRB);
    assign ifb.BRZ = (age1 >= 3) ? f(ifb.BRA, ifb.BRB) : 8'hEE;

    logic [1:0] m_gnt [2], m_ack [2];
    logic [7:0] m_bra [2], m_brb [2], m_res [2];
    logic       m_busy [2];
    int         m_ptr [2], m_t [2];
    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_gnt[k] = '0; m_ack[k] = '0; m_bra[k] = '0; m_brb[k] = '0;
            m_res[k] = '0; m_busy[k] = 1'b0; m_ptr[k] = 1; m_t[k] = -1;
        end
    endtask

    // m_t counts edges since the grant; -1 means no transaction in flight
    task automatic model_step(input int k);
        int lat, w;
        lat = (k == 0) ? 1 : 4;
        if (m_t[k] < 0) begin
            if (d_ena[k] && d_req[k] != 2'b00) begin
`ifdef BRIDGE_SEQ_FIXPRIO_EN
                w = d_req[k][0] ? 0 : 1;
`else
                w = (d_req[k] == 2'b11) ? 1 - m_ptr[k] : (d_req[k][1] ? 1 : 0);
                m_ptr[k] = w;
`endif
                m_gnt[k] = (w == 1) ? 2'b10 : 2'b01;
                m_bra[k] = (w == 1) ? d_a1[k] : d_a0[k];
                m_brb[k] = (w == 1) ? d_b1[k] : d_b0[k];
                m_busy[k] = 1'b1;
                m_t[k] = 0;
            end
        end else begin
            m_t[k]++;
            if (m_t[k] == lat) begin
                m_res[k] = f(m_bra[k], m_brb[k]);
                m_ack[k] = m_gnt[k];
            end else if (m_t[k] == lat + 1) begin
                m_ack[k] = '0; m_gnt[k] = '0; m_busy[k] = 1'b0; m_t[k] = -1;
            end
        end
    endtask

    task automatic check_all();
        chk("gnt_l1", ifa.GNT, m_gnt[0]);
        chk("ack_l1", ifa.ACK, m_ack[0]);
        chk("bra_l1", ifa.BRA, m_bra[0]);
        chk("brb_l1", ifa.BRB, m_brb[0]);
        chk("res_l1", ifa.RES, m_res[0]);
        chk("busy_l1", ifa.BUSY, m_busy[0]);
        chk("gnt_l4", ifb.GNT, m_gnt[1]);
        chk("ack_l4", ifb.ACK, m_ack[1]);
        chk("bra_l4", ifb.BRA, m_bra[1]);
        chk("brb_l4", ifb.BRB, m_brb[1]);
        chk("res_l4", ifb.RES, m_res[1]);
        chk("busy_l4", ifb.BUSY, m_busy[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        #1 check_all();
        @(negedge clk);
    endtask

    task automatic zero_checks(input string tag);
        chk({tag, "_gnt"}, {ifa.GNT, ifb.GNT}, 0);
        chk({tag, "_ack"}, {ifa.ACK, ifb.ACK}, 0);
        chk({tag, "_busy"}, {ifa.BUSY, ifb.BUSY}, 0);
        chk({tag, "_bra"}, {ifa.BRA, ifb.BRA}, 0);
        chk({tag, "_brb"}, {ifa.BRB, ifb.BRB}, 0);
        chk({tag, "_res"}, {ifa.RES, ifb.RES}, 0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        d_req[0] = '0;
        d_req[1] = '0;
        model_reset();
        #1 zero_checks("rst_async");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int g_ord [4];
        int a_cyc [4];
        int ng, na, ack_idx, busy_cnt;
        logic [1:0] pg;
        for (int k = 0; k < 2; k++) begin
            d_ena[k] = 1'b1; d_req[k] = '0;
            d_a0[k] = '0; d_b0[k] = '0; d_a1[k] = '0; d_b1[k] = '0;
        end
        model_reset();
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        #1 zero_checks("reset");

        // single request, LAT=1
        d_req[0] = 2'b01; d_a0[0] = 8'h07; d_b0[0] = 8'h01;
        tick();
        chk("single_gnt", ifa.GNT, 2'b01);
        chk("single_bra", ifa.BRA, 8'h07);
        chk("single_brb", ifa.BRB, 8'h01);
        chk("single_ack_early", ifa.ACK, 2'b00);
        tick();
        chk("single_ack", ifa.ACK, 2'b01);
        chk("single_res", ifa.RES, 8'h2b);
        d_req[0] = 2'b00;
        tick();
        chk("single_ack_once", ifa.ACK, 2'b00);
        chk("single_res_hold", ifa.RES, 8'h2b);
        tick();

        // contention from a fresh pointer
        do_reset();
        d_req[0] = 2'b11; d_a0[0] = 8'h02; d_b0[0] = 8'h11; d_a1[0] = 8'h05; d_b1[0] = 8'h22;
        g_ord = '{-1, -1, -1, -1};
        a_cyc = '{-100, -100, -100, -100};
        ng = 0; na = 0; pg = '0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (ifa.GNT != 2'b00 && pg == 2'b00 && ng < 4) begin
                g_ord[ng] = ifa.GNT[1] ? 1 : 0;
                ng++;
            end
            pg = ifa.GNT;
            if (ifa.ACK != 2'b00 && na < 4) begin
                a_cyc[na] = i;
                na++;
            end
        end
        for (int i = 0; i < 4; i++)
`ifdef BRIDGE_SEQ_FIXPRIO_EN
            chk($sformatf("cont_order%0d", i), g_ord[i], 0);
`else
            chk($sformatf("cont_order%0d", i), g_ord[i], i % 2);
`endif
        for (int i = 0; i < 3; i++)
            chk($sformatf("cont_ack_gap%0d", i), a_cyc[i+1] - a_cyc[i], 3);
        d_req[0] = 2'b00;
        repeat (3) tick();

        // LAT=4 single request from requester 1
        d_req[1] = 2'b10; d_a1[1] = 8'h03; d_b1[1] = 8'h20;
        tick();
        chk("lat4_gnt", ifb.GNT, 2'b10);
        busy_cnt = ifb.BUSY ? 1 : 0;
        ack_idx = -1;
        for (int i = 2; i <= 10; i++) begin
            tick();
            if (ifb.BUSY) busy_cnt++;
            if (ifb.ACK == 2'b10) begin
                ack_idx = i;
                d_req[1] = 2'b00;
            end
        end
        chk("lat4_ack_cycle", ack_idx, 5);
        chk("lat4_busy_cycles", busy_cnt, 5);
        chk("lat4_res", ifb.RES, 8'h39);

        // ENA low and request drop during a transaction
        d_req[0] = 2'b01; d_a0[0] = 8'h44; d_b0[0] = 8'h55;
        tick();
        chk("ena_gnt", ifa.GNT, 2'b01);
        d_ena[0] = 1'b0; d_req[0] = 2'b10; d_a1[0] = 8'h66; d_b1[0] = 8'h77;
        tick();
        chk("ena_ack", ifa.ACK, 2'b01);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ena_blocked%0d", i), ifa.GNT, 2'b00);
        end
        d_ena[0] = 1'b1;
        tick();
        chk("ena_regrant", ifa.GNT, 2'b10);
        d_req[0] = 2'b00;
        repeat (3) tick();

        // reset in the middle of a LAT=4 wait
        d_req[1] = 2'b01; d_a0[1] = 8'h9a; d_b0[1] = 8'hbc;
        tick();
        tick();
        tick();
        do_reset();
        d_req[1] = 2'b11;
        tick();
        chk("post_reset_gnt", ifb.GNT, 2'b01);
        d_req[1] = 2'b00;
        repeat (6) tick();

        // randomized traffic on both instances
        for (int n = 0; n < 4000; n++) begin
            if (n % 1000 == 999) do_reset();
            for (int k = 0; k < 2; k++) begin
                d_ena[k] = ($urandom_range(7) != 0);
                for (int r = 0; r < 2; r++) begin
                    if (d_req[k][r]) begin
                        if (m_ack[k][r] ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0))
                            d_req[k][r] = 1'b0;
                    end else if ($urandom_range(2) == 0) begin
                        d_req[k][r] = 1'b1;
                        if (r == 0) begin
                            d_a0[k] = 8'($urandom); d_b0[k] = 8'($urandom);
                        end else begin
                            d_a1[k] = 8'($urandom); d_b1[k] = 8'($urandom);
                        end
                    end
                end
            end
            tick();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bridge_sequencer.md
# bridge_sequencer

Two-port arbiter and sequencer for the 8-bit `bridge` datapath in the protection-cell FPGA design. It grants one of two requesters exclusive use of the bridge, drives the operands onto the bridge's `RGA`/`RGB` inputs, waits a configurable settle latency, and captures `RGZ`. It then returns the captured result to the granted requester with a one-cycle acknowledge. The block sits between the protection logic (the requesters) and the combinational `bridge` instance.

## Interface
- `W`, default 8: datapath width of operands and result.
- `LAT`, default 1: number of bridge settle cycles between operand launch and result capture. Legal range is 1..15; 0 is illegal.

- `CLK` input, 1 bit: single clock, rising edge.
- `RST` input, 1 bit: reset, asynchronous and active-low. All state clears while `RST`=0.
- `ENA` input, 1 bit: global enable. When low, no new transaction starts.
- `REQ0`, `REQ1` input, 1 bit each: level request from requester 0 and requester 1.
- `A0`, `B0` input, W bits: operands from requester 0.
- `A1`, `B1` input, W bits: operands from requester 1.
- `BRA` output, W bits: to bridge `RGA`.
- `BRB` output, W bits: to bridge `RGB`.
- `BRZ` input, W bits: from bridge `RGZ`.
- `GNT` output, 2 bits: one-hot grant, where bit i belongs to requester i.
- `ACK` output, 2 bits: one-cycle completion pulse, where bit i belongs to requester i.
- `RES` output, W bits: captured result. It holds its value until the next capture.
- `BUSY` output, 1 bit: high when the state is WAIT or DONE.

## Operation
- The FSM has three states: IDLE, WAIT and DONE.
- **IDLE:**
  - If `ENA`=1 and any `REQ` is high, select a winner.
  - Register the winner's A/B into `BRA`/`BRB`, set its `GNT` bit, load the counter with LAT-1, and go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT:**
  - If the counter is not 0, decrement it.
  - If the counter is 0, set `RES`<=`BRZ`, set the granted `ACK` bit, and go to DONE.
- **DONE:** clear `ACK`, clear `GNT`, and go to IDLE. No arbitration takes place in DONE.
- **Arbitration:** round-robin on a last-grant pointer.
  - A single request wins outright.
  - When both requests are high, the requester not granted last wins.
  - The pointer resets to 1, so requester 0 wins the first contention.
  - The pointer updates on every grant.
- **Handshake:**
  - Each grant produces exactly one `ACK` pulse.
  - The requester must hold `A`/`B` stable from raising `REQ` until `ACK`.
  - The requester deasserts `REQ` in the `ACK` cycle. A `REQ` still high when IDLE next evaluates starts a new transaction.
- **Request drop:** if `REQ` drops during WAIT, the transaction still completes and `ACK` still pulses.
- **`ENA` low mid-transaction:** the in-flight transaction completes. Only new grants are blocked.
- **Holding registers:** `BRA`/`BRB` hold their last values after completion. They are not zeroed.
- **Counter:** 4 bits, unsigned, with no wrap. It never decrements below 0.

## Timing
- Reset values:
  - State = IDLE, pointer = 1.
  - `GNT`=00, `ACK`=00, `BUSY`=0.
  - `BRA`=`BRB`=`RES`=0.
- Latency:
  - The grant edge is e0, where `GNT`/`BRA`/`BRB` become valid.
  - `BRZ` is sampled at edge e0+LAT.
  - `ACK` and the new `RES` are high/valid for the cycle after e0+LAT.
  - `GNT` clears at e0+LAT+1.
- Throughput: the earliest next grant is at e0+LAT+2, so there is one transaction per LAT+2 cycles.
- Reset mid-operation: asserting `RST` in any state returns all outputs to their reset values immediately (asynchronously). No `ACK` is issued for the aborted transaction.
- Outputs are fully registered, with no combinational path from inputs to outputs.

## Configuration
- Macro: `BRIDGE_SEQ_FIXPRIO_EN`.
- Defined: fixed priority. Requester 0 always wins contention, and the pointer logic is removed.
- Undefined (default): round-robin as described in Operation.

## Test plan
- **Reset:** hold `RST`=0 for 20 ns, then release. Required: all outputs 0 and `BUSY`=0.
- **Single request, LAT=1:**
  - Stimulus: `REQ0`=1, `A0`=8'h07, `B0`=8'h01, and the bridge model gives `RGZ`=f(A,B).
  - Required: `GNT`=01 at e0, `BRA`=07, `BRB`=01, `ACK`=01 for exactly one cycle after e1, `RES`=f(07,01).
- **Contention:**
  - Stimulus: `REQ0`=`REQ1`=1 continuously, with `A0`=8'h02 and `A1`=8'h05.
  - Required: grant order 0,1,0,1 and `ACK` spacing of 3 cycles. With `BRIDGE_SEQ_FIXPRIO_EN` defined, the order is 0,0,0,0.
- **LAT=4:**
  - Stimulus: `REQ1`=1 with `A1`=8'h03.
  - Required: `BRZ` sampled 4 edges after grant, `ACK`=10 in the 5th cycle, `BUSY` high for 5 cycles.
- **`ENA` and drop:**
  - Stimulus: drop `ENA` and `REQ0` one cycle after grant.
  - Required: `ACK`=01 still pulses. No new grant occurs while `ENA`=0 even with `REQ1`=1. The grant occurs 1 edge after `ENA` rises.
- **Reset mid-WAIT:**
  - Stimulus: with LAT=4, assert `RST`=0 two cycles after grant.
  - Required: `GNT`=00, `BUSY`=0 and `BRA`=0 immediately, with no `ACK` pulse. The first post-reset contention grants requester 0.
